// File: rtl/uart_rx_frame_counter_if.sv
// Handshake and status bundle between the RX start detector/FSM and the
// frame counter.
interface uart_rx_frame_counter_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);
  logic                  start;
  logic                  enable;
  logic                  reset_cnt;
  logic [PRESCALE_W-1:0] prescale;
  logic [BIT_CNT_W-1:0]  frame_bits;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  smp_early;
  logic                  smp_mid;
  logic                  smp_late;
  logic                  bit_done;
  logic                  frame_done;
  logic                  busy;
  logic                  cfg_err;

  modport master (
    output start, enable, reset_cnt, prescale, frame_bits,
    input  edge_cnt, bit_cnt, smp_early, smp_mid, smp_late,
           bit_done, frame_done, busy, cfg_err
  );

  modport slave (
    input  start, enable, reset_cnt, prescale, frame_bits,
    output edge_cnt, bit_cnt, smp_early, smp_mid, smp_late,
           bit_done, frame_done, busy, cfg_err
  );
endinterface

// File: rtl/uart_rx_frame_counter.sv
// Oversampling edge/bit/frame counter for the UART receive path: latches
// prescale and frame length at start and emits sample, bit and frame strobes.
module uart_rx_frame_counter #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input logic                     clk,
  input logic                     rst,
  uart_rx_frame_counter_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [BIT_CNT_W-1:0]  frame_q, frame_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  cfg_legal;
  logic                  last_edge;
  logic                  last_bit;
  logic                  tick;
  logic [PRESCALE_W-1:0] mid;

  // Odd prescale has no centred sample point; all-ones is odd and excluded too.
  assign cfg_legal = (bus.prescale >= PRESCALE_W'(4)) && !bus.prescale[0] &&
                     (bus.prescale != '1) && (bus.frame_bits >= BIT_CNT_W'(2));

  assign last_edge = (edge_q == prescale_q);
  assign last_bit  = (bit_q == frame_q - BIT_CNT_W'(1));
  assign mid       = prescale_q >> 1;
  assign tick      = (state_q == RUN) && bus.enable && !bus.reset_cnt && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      prescale_q <= '0;
      frame_q    <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      prescale_q <= prescale_d;
      frame_q    <= frame_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    prescale_d = prescale_q;
    frame_d    = frame_q;
    cfg_err_d  = cfg_err_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.reset_cnt && bus.start) begin
          if (cfg_legal) begin
            state_d    = RUN;
            prescale_d = bus.prescale;
            frame_d    = bus.frame_bits;
            edge_d     = PRESCALE_W'(1);
            bit_d      = '0;
            cfg_err_d  = 1'b0;
          end else begin
            cfg_err_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.reset_cnt) begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end else if (bus.enable) begin
          if (!last_edge) begin
            edge_d = edge_q + PRESCALE_W'(1);
          end else if (!last_bit) begin
            edge_d = PRESCALE_W'(1);
            bit_d  = bit_q + BIT_CNT_W'(1);
          end else begin
            state_d = IDLE;
            edge_d  = '0;
            bit_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.edge_cnt   = edge_q;
  assign bus.bit_cnt    = bit_q;
  assign bus.smp_early  = tick && (edge_q == mid - PRESCALE_W'(1));
  assign bus.smp_mid    = tick && (edge_q == mid);
  assign bus.smp_late   = tick && (edge_q == mid + PRESCALE_W'(1));
  assign bus.bit_done   = tick && last_edge;
  assign bus.frame_done = tick && last_edge && last_bit;
  assign bus.busy       = (state_q == RUN);
  assign bus.cfg_err    = cfg_err_q;

endmodule

// File: doc/uart_rx_frame_counter.md
# uart_rx_frame_counter

Parametrised oversampling edge/bit/frame counter for the UART receive path. It is the successor to the fixed 4-bit edge/bit counter. It latches a per-frame prescale and frame length at start and tracks oversampling ticks and bit positions. It emits three majority-vote sample strobes, a bit-done strobe and a frame-done strobe, and flags illegal configuration. It sits between the RX start detector/FSM and the data sampler/deserializer.

## Interface
- PRESCALE_W, 6 — width of prescale and edge_cnt; legal prescale 4..2^PRESCALE_W−2, even.
- BIT_CNT_W, 4 — width of frame_bits and bit_cnt; legal frame_bits 2..2^BIT_CNT_W−1.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse coincident with the first oversampling tick of the start bit.
- enable  input  1  oversampling tick; counting advances only when high.
- reset_cnt  input  1  abort current frame.
- prescale  input  PRESCALE_W  oversampling ratio, sampled only on accepted start.
- frame_bits  input  BIT_CNT_W  total bits per frame (start+data+parity+stop), sampled only on accepted start.
- edge_cnt  output  PRESCALE_W  tick index within current bit, 1..prescale_q; 0 when idle.
- bit_cnt  output  BIT_CNT_W  bit index within frame, 0..frame_q−1; 0 when idle.
- smp_early, smp_mid, smp_late  output  1 each  sample strobes.
- bit_done  output  1  last tick of a bit.
- frame_done  output  1  last tick of the last bit.
- busy  output  1  frame in progress.
- cfg_err  output  1  sticky illegal-configuration flag.

## Operation
- Two states: IDLE and RUN. The registers are state, edge_cnt, bit_cnt, prescale_q, frame_q and cfg_err.
- **IDLE, start=1, legal config:**
  - Go to RUN.
  - Set prescale_q=prescale and frame_q=frame_bits.
  - Set edge_cnt=1 and bit_cnt=0.
  - Clear cfg_err.
  - A coincident enable is consumed by the load; it is not counted twice.
- **IDLE, start=1, illegal config** (prescale<4, prescale odd, prescale=2^PRESCALE_W−1, or frame_bits<2):
  - Stay in IDLE.
  - Set cfg_err=1.
  - Counters stay 0.
- **IDLE, start=0:** hold all state.
- **RUN, enable=1, edge_cnt≠prescale_q:** edge_cnt+1.
- **RUN, enable=1, edge_cnt==prescale_q, bit_cnt<frame_q−1:** edge_cnt=1, bit_cnt+1.
- **RUN, enable=1, edge_cnt==prescale_q, bit_cnt==frame_q−1:** go to IDLE, edge_cnt=0, bit_cnt=0.
- **RUN, enable=0:** hold.
- **start in RUN:** ignored; prescale/frame_bits changes during RUN have no effect.
- **reset_cnt in RUN:** go to IDLE with counters 0 next cycle; no strobes in that cycle. In IDLE it has no effect.
- **Priority:** rst > reset_cnt > start > counting.
- **Strobes** are combinational from registered state and qualified by state==RUN && enable && !reset_cnt. With mid = prescale_q>>1:
  - smp_early when edge_cnt==mid−1.
  - smp_mid when edge_cnt==mid.
  - smp_late when edge_cnt==mid+1.
  - bit_done when edge_cnt==prescale_q.
  - frame_done when bit_done && bit_cnt==frame_q−1.
- busy = (state==RUN).
- **Arithmetic:** counters are unsigned and never wrap. Legal ranges guarantee edge_cnt ≤ prescale_q < 2^PRESCALE_W and bit_cnt < 2^BIT_CNT_W.

## Timing
- Reset values: state=IDLE, edge_cnt=0, bit_cnt=0, prescale_q=0, frame_q=0, cfg_err=0, busy=0. All strobes are 0.
- rst asserted mid-frame: everything returns to reset values at the next edge, and no strobes fire in the rst cycle.
- Latency:
  - start accepted in cycle 0 gives busy=1 and edge_cnt=1 in cycle 1.
  - Strobes are same-cycle with the qualifying enable.
  - busy falls the cycle after frame_done.
- With enable continuously high, one bit lasts prescale_q cycles and one frame lasts prescale_q×frame_q cycles after start.
- Back-to-back frames: start may be asserted in the cycle after frame_done and is accepted. start in the frame_done cycle itself is ignored, because the block is still in RUN.
- Each strobe is high for at most one cycle per bit. Sample strobes never coincide with bit_done for legal prescale.

## Test plan
- **Nominal frame:** rst, then prescale=8, frame_bits=10, enable=1 continuously, start at cycle 0. Required response:
  - smp_early/mid/late at cycles 3/4/5 of each bit.
  - bit_done at cycles 8,16,…,80.
  - frame_done only at cycle 80.
  - busy=0 from cycle 81.
- **Gapped ticks:** prescale=16, frame_bits=2, enable high every 3rd cycle. Required response:
  - edge_cnt advances only on enabled cycles.
  - frame_done on the 32nd enabled tick after start.
  - smp_mid on the 8th and 24th ticks.
- **Illegal config:** start with prescale=7, then with prescale=2, then with frame_bits=1. Required response:
  - busy stays 0.
  - cfg_err=1 from the cycle after the first attempt.
  - A following start with prescale=4, frame_bits=2 clears cfg_err and runs 8 cycles.
- **Abort and mid-frame changes:** prescale=8, frame_bits=10. Assert reset_cnt at bit_cnt=3, edge_cnt=5. Required response:
  - No strobe in that cycle.
  - Next cycle busy=0, edge_cnt=0, bit_cnt=0.
  - A mid-frame change of prescale to 4 does not alter bit length.
- **Simultaneous events:**
  - start+enable in IDLE gives edge_cnt=1, not 2.
  - reset_cnt+bit_done gives abort wins, no bit_done.
  - start in the frame_done cycle is ignored; start one cycle later is accepted.
- **Reset mid-frame:** assert rst at bit_cnt=5. Required response: all outputs return to reset values next cycle, and a new start works normally.
